// File: rtl/mixer_nch.sv
// N-channel sample mixer: per-channel latches and gains, summed one channel per clock
// on an execute strobe, then shifted, saturated and registered for the DAC stage.
module mixer_nch #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int L     = 3,
    parameter int SHIFT = 2,
    parameter int OUT_W = 10
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N_CH*W-1:0]   i_samples,
    input  logic [N_CH-1:0]     i_load,
    input  logic [N_CH*L-1:0]   i_levels,
    input  logic [N_CH-1:0]     i_mute,
    input  logic                i_execute,
    output logic                o_busy,
    output logic                o_valid,
    output logic                o_clip,
    output logic [OUT_W-1:0]    o_output
);

    localparam int AW      = W + L + $clog2(N_CH);
    localparam int IW      = $clog2(N_CH);
    localparam int PW      = W + L;
    localparam int RW      = (AW > OUT_W) ? AW : OUT_W;
    localparam int OUT_MAX = (1 << OUT_W) - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_latch [N_CH];
    logic [W-1:0]    r_snap  [N_CH];
    logic [L-1:0]    r_lvl   [N_CH];
    logic [N_CH-1:0] r_mute;
    logic [AW-1:0]   r_acc;
    logic [IW-1:0]   r_idx;
    logic [PW-1:0]   w_term;
    logic [RW-1:0]   w_shifted;
    logic            w_sat;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_CH; k++) r_latch[k] <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (i_load[k]) r_latch[k] <= i_samples[k*W +: W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_execute) w_next = ACCUM;
            ACCUM:   if (r_idx == LAST_IDX) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Muted or zero-level channels contribute nothing; products never overflow PW bits.
    always_comb begin
        w_term = '0;
        if (!r_mute[r_idx]) w_term = PW'(r_snap[r_idx]) * PW'(r_lvl[r_idx]);
    end

    always_comb begin
        w_shifted = RW'(r_acc >> SHIFT);
        w_sat     = (w_shifted > RW'(OUT_MAX));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                r_snap[k] <= '0;
                r_lvl[k]  <= '0;
            end
            r_mute   <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_clip   <= 1'b0;
            o_output <= '0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_execute) begin
                        // Snapshot reads the pre-edge latch, so a same-cycle load is not seen.
                        for (int k = 0; k < N_CH; k++) begin
                            r_snap[k] <= r_latch[k];
                            r_lvl[k]  <= i_levels[k*L +: L];
                        end
                        r_mute <= i_mute;
                        r_acc  <= '0;
                        r_idx  <= '0;
                        o_busy <= 1'b1;
                    end
                end
                ACCUM: begin
                    r_acc <= r_acc + AW'(w_term);
                    r_idx <= r_idx + 1'b1;
                end
                DONE: begin
                    o_output <= w_sat ? {OUT_W{1'b1}} : w_shifted[OUT_W-1:0];
                    o_clip   <= w_sat;
                    o_valid  <= 1'b1;
                    o_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mixer_nch.sv
// Directed bench for mixer_nch (N_CH=4, W=8, L=3, SHIFT=2, OUT_W=10); expected
// values are hand-computed from the mixing rule.
module tb_mixer_nch;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_samples;
    logic [3:0]  i_load;
    logic [11:0] i_levels;
    logic [3:0]  i_mute;
    logic        i_execute;
    logic        o_busy;
    logic        o_valid;
    logic        o_clip;
    logic [9:0]  o_output;

    int checkCount = 0;
    int errorCount = 0;
    int cycles;
    int validCount;
    logic [9:0] seenOutput;

    mixer_nch #(.N_CH(4), .W(8), .L(3), .SHIFT(2), .OUT_W(10)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_samples (i_samples),
        .i_load    (i_load),
        .i_levels  (i_levels),
        .i_mute    (i_mute),
        .i_execute (i_execute),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_clip    (o_clip),
        .o_output  (o_output)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it, so samples never race the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic loadChannel(input int ch, input logic [7:0] val);
        i_samples[ch*8 +: 8] = val;
        i_load = 4'b0001 << ch;
        tick();
        i_load = '0;
    endtask

    task automatic setLevel(input int ch, input logic [2:0] lvl);
        i_levels[ch*3 +: 3] = lvl;
    endtask

    task automatic applyStimulus();
        i_execute = 1'b1;
        tick();
        i_execute = 1'b0;
    endtask

    task automatic waitValid(input int maxCycles, output int seen);
        seen = -1;
        for (int i = 1; i <= maxCycles; i++) begin
            tick();
            if (o_valid) begin
                seen = i;
                break;
            end
        end
    endtask

    task automatic countValids(input int n, output int count, output logic [9:0] lastOut);
        count = 0;
        lastOut = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_valid) begin
                count++;
                lastOut = o_output;
            end
        end
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_samples = '0;
        i_load    = '0;
        i_levels  = '0;
        i_mute    = '0;
        i_execute = 1'b0;
        tick();
        tick();
        checkOutput("reset_busy", 32'(o_busy), 0);
        checkOutput("reset_valid", 32'(o_valid), 0);
        checkOutput("reset_clip", 32'(o_clip), 0);
        checkOutput("reset_output", 32'(o_output), 0);
        i_rst_n = 1'b1;
        tick();

        $display("[TB] single channel");
        loadChannel(0, 8'd100);
        setLevel(0, 3'd4);
        applyStimulus();
        checkOutput("single_busy", 32'(o_busy), 1);
        waitValid(20, cycles);
        checkOutput("single_latency", 32'(cycles), 5);
        checkOutput("single_output", 32'(o_output), 100);
        checkOutput("single_clip", 32'(o_clip), 0);
        checkOutput("single_busy_done", 32'(o_busy), 0);
        tick();
        checkOutput("single_valid_width", 32'(o_valid), 0);
        checkOutput("single_hold", 32'(o_output), 100);

        $display("[TB] full scale");
        i_samples = {4{8'd255}};
        i_load = 4'hF;
        tick();
        i_load = '0;
        i_levels = {4{3'd4}};
        applyStimulus();
        waitValid(20, cycles);
        checkOutput("full_unity_output", 32'(o_output), 1020);
        checkOutput("full_unity_clip", 32'(o_clip), 0);
        i_levels = {4{3'd7}};
        applyStimulus();
        waitValid(20, cycles);
        checkOutput("full_sat_output", 32'(o_output), 1023);
        checkOutput("full_sat_clip", 32'(o_clip), 1);
        tick();
        checkOutput("clip_hold", 32'(o_clip), 1);

        $display("[TB] mute and floor");
        loadChannel(0, 8'd3);
        loadChannel(1, 8'd200);
        i_levels = '0;
        setLevel(0, 3'd1);
        setLevel(1, 3'd4);
        i_mute = 4'b0010;
        applyStimulus();
        waitValid(20, cycles);
        checkOutput("mute_output", 32'(o_output), 0);
        checkOutput("mute_clip", 32'(o_clip), 0);
        i_mute = '0;

        $display("[TB] busy protection");
        loadChannel(0, 8'd20);
        i_levels = '0;
        setLevel(0, 3'd4);
        applyStimulus();
        tick();
        i_execute = 1'b1;
        i_samples[7:0] = 8'd50;
        i_load = 4'b0001;
        tick();
        i_execute = 1'b0;
        i_load = '0;
        countValids(15, validCount, seenOutput);
        checkOutput("busy_valid_count", 32'(validCount), 1);
        checkOutput("busy_old_sample", 32'(seenOutput), 20);
        applyStimulus();
        waitValid(20, cycles);
        checkOutput("busy_new_sample", 32'(o_output), 50);

        $display("[TB] reset mid-mix");
        applyStimulus();
        tick();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        checkOutput("midrst_busy", 32'(o_busy), 0);
        checkOutput("midrst_output", 32'(o_output), 0);
        checkOutput("midrst_valid", 32'(o_valid), 0);
        countValids(10, validCount, seenOutput);
        checkOutput("midrst_no_valid", 32'(validCount), 0);
        applyStimulus();
        waitValid(20, cycles);
        checkOutput("midrst_latency", 32'(cycles), 5);
        checkOutput("midrst_cleared", 32'(o_output), 0);

        $display("[TB] back-to-back with same-cycle load");
        loadChannel(0, 8'd40);
        setLevel(0, 3'd4);
        applyStimulus();
        waitValid(20, cycles);
        checkOutput("b2b_first_output", 32'(o_output), 40);
        setLevel(0, 3'd2);
        i_samples[7:0] = 8'd60;
        i_load = 4'b0001;
        i_execute = 1'b1;
        tick();
        i_execute = 1'b0;
        i_load = '0;
        checkOutput("b2b_valid_drop", 32'(o_valid), 0);
        checkOutput("b2b_busy", 32'(o_busy), 1);
        waitValid(20, cycles);
        checkOutput("b2b_latency", 32'(cycles), 5);
        checkOutput("b2b_old_snapshot", 32'(o_output), 20);
        applyStimulus();
        waitValid(20, cycles);
        checkOutput("b2b_new_latch", 32'(o_output), 30);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
